// File: rtl/rom_port_arbiter.sv
// Round-robin two-port req/gnt/rvalid front end for a single-read-port OpenROM macro.
// Optional one-entry last-read buffer is compiled in when ROM_LINE_BUF_EN is defined.

module rom_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [1:0]              p_req_i,
    input  logic [1:0]              p_we_i,
    input  logic [63:0]             p_addr_i,
    output logic [1:0]              p_gnt_o,
    output logic [1:0]              p_rvalid_o,
    output logic [1:0]              p_err_o,
    output logic [2*DATA_WIDTH-1:0] p_rdata_o,
    output logic                    rom_csb_o,
    output logic [ADDR_WIDTH-1:0]   rom_addr_o,
    input  logic [DATA_WIDTH-1:0]   rom_dout_i
);

    typedef struct packed {
        logic                  valid;
        logic                  port;
        logic                  err;
`ifdef ROM_LINE_BUF_EN
        logic                  hit;
        logic [ADDR_WIDTH-1:0] word;
        logic [DATA_WIDTH-1:0] data;
`endif
    } tag_t;

    logic                  prio_q, prio_d;
    logic                  gnt_any, gnt_port;
    logic [31:0]           sel_addr, off;
    logic                  in_range, legal, hit, rom_access;
    logic [ADDR_WIDTH-1:0] word;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    tag_t                  issue_tag, resp;
    tag_t                  stage_q [RD_LATENCY];
    logic [DATA_WIDTH-1:0] resp_data;
    logic [DATA_WIDTH-1:0] rdata_q [2];
    logic [DATA_WIDTH-1:0] rdata_d [2];

    // NOTE: every always_comb output gets a default before any branch, so no path infers a latch.
    always_comb begin
        gnt_port = 1'b0;
        unique case (p_req_i)
            2'b10:   gnt_port = 1'b1;
            2'b11:   gnt_port = prio_q;
            default: gnt_port = 1'b0;
        endcase
        // Grants are held off during reset so requesters never see a grant that would be lost.
        gnt_any = rst_ni & (|p_req_i);
        p_gnt_o = {gnt_any & gnt_port, gnt_any & ~gnt_port};
        prio_d  = gnt_any ? ~gnt_port : prio_q;
    end

    always_comb begin
        sel_addr = gnt_port ? p_addr_i[63:32] : p_addr_i[31:0];
        off      = sel_addr - BASE_ADDR;
        in_range = (off >> (ADDR_WIDTH + 2)) == 32'd0;
        word     = off[ADDR_WIDTH+1:2];
        legal    = gnt_any & ~p_we_i[gnt_port] & in_range;
    end

`ifdef ROM_LINE_BUF_EN
    logic                  buf_valid_q;
    logic [ADDR_WIDTH-1:0] buf_tag_q;
    logic [DATA_WIDTH-1:0] buf_data_q;

    assign hit = legal & buf_valid_q & (buf_tag_q == word);

    // Only words that actually came from the ROM refill the buffer; hits carry identical data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
        end else if (resp.valid & ~resp.err & ~resp.hit) begin
            buf_valid_q <= 1'b1;
            buf_tag_q   <= resp.word;
            buf_data_q  <= rom_dout_i;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        rom_access = legal & ~hit;
        rom_csb_o  = ~rom_access;
        rom_addr_o = rom_access ? word : rom_addr_q;
        rom_addr_d = rom_addr_o;
    end

    always_comb begin
        issue_tag       = '0;
        issue_tag.valid = gnt_any;
        issue_tag.port  = gnt_port;
        issue_tag.err   = gnt_any & ~legal;
`ifdef ROM_LINE_BUF_EN
        issue_tag.hit   = hit;
        issue_tag.word  = word;
        issue_tag.data  = buf_data_q;
`endif
    end

    assign resp = stage_q[RD_LATENCY-1];

    // The oldest tag selects which port sees rom_dout_i this cycle; other ports hold their data.
    always_comb begin
        resp_data = rom_dout_i;
`ifdef ROM_LINE_BUF_EN
        if (resp.hit) resp_data = resp.data;
`endif
        if (resp.err) resp_data = '0;
        for (int p = 0; p < 2; p++) begin
            p_rvalid_o[p] = resp.valid & (int'(resp.port) == p);
            p_err_o[p]    = p_rvalid_o[p] & resp.err;
            rdata_d[p]    = p_rvalid_o[p] ? resp_data : rdata_q[p];
            p_rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = rdata_d[p];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q     <= 1'b0;
            rom_addr_q <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
            // NOTE: the tag pipeline is reset (not just its data) because a stale valid bit would emit a phantom response.
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            prio_q     <= prio_d;
            rom_addr_q <= rom_addr_d;
            rdata_q[0] <= rdata_d[0];
            rdata_q[1] <= rdata_d[1];
            stage_q[0] <= issue_tag;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench: RD_LATENCY=1 and RD_LATENCY=3 instances share stimulus and are
// compared every cycle against a transaction-level reference model with a behavioural ROM.

module tb_rom_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [1:0]  req = '0;
    logic [1:0]  we = '0;
    logic [63:0] addr = '0;

    logic [1:0]  gnt [2];
    logic [1:0]  rvalid [2];
    logic [1:0]  err [2];
    logic [63:0] rdata [2];
    logic        csb [2];
    logic [9:0]  raddr [2];
    logic [31:0] dout [2];

    logic [31:0] mem [1024];

    always #5 clk_i = ~clk_i;

    rom_port_arbiter #(.RD_LATENCY(1)) u_lat1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .p_req_i(req), .p_we_i(we), .p_addr_i(addr),
        .p_gnt_o(gnt[0]), .p_rvalid_o(rvalid[0]), .p_err_o(err[0]), .p_rdata_o(rdata[0]),
        .rom_csb_o(csb[0]), .rom_addr_o(raddr[0]), .rom_dout_i(dout[0])
    );

    rom_port_arbiter #(.RD_LATENCY(3)) u_lat3 (
        .clk_i(clk_i), .rst_ni(rst_ni), .p_req_i(req), .p_we_i(we), .p_addr_i(addr),
        .p_gnt_o(gnt[1]), .p_rvalid_o(rvalid[1]), .p_err_o(err[1]), .p_rdata_o(rdata[1]),
        .rom_csb_o(csb[1]), .rom_addr_o(raddr[1]), .rom_dout_i(dout[1])
    );

    // Behavioural ROMs: address captured at the issue edge, data shown until the L-th edge after it.
    int rom1_w = -1;
    int rom3_w [3] = '{-1, -1, -1};
    always @(posedge clk_i) begin
        rom1_w    <= csb[0] ? -1 : int'(raddr[0]);
        rom3_w[0] <= csb[1] ? -1 : int'(raddr[1]);
        rom3_w[1] <= rom3_w[0];
        rom3_w[2] <= rom3_w[1];
    end
    assign dout[0] = (rom1_w >= 0)    ? mem[rom1_w]    : 32'h5A5A_5A5A;
    assign dout[1] = (rom3_w[2] >= 0) ? mem[rom3_w[2]] : 32'h5A5A_5A5A;

    typedef struct {
        bit          v;
        int          port;
        bit          err;
        logic [31:0] data;
        bit          fill;
        int          word;
    } exp_t;

    exp_t        slot [2][8];
    logic [31:0] held [2][2];
    bit          buf_v [2];
    int          buf_w [2];
    int          last_addr [2];
    int          last_gnt;
    int          cyc;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++) slot[d][k].v = 1'b0;
            held[d][0]   = '0;
            held[d][1]   = '0;
            buf_v[d]     = 1'b0;
            buf_w[d]     = 0;
            last_addr[d] = 0;
        end
        last_gnt = 1;
    endtask

    // Compares one cycle of both DUTs with the model, then advances the model past this cycle.
    task automatic cycle_check();
        int          g;
        bit          legal;
        bit          hit;
        bit          access;
        int          word;
        logic [31:0] off;
        exp_t        s;
        string       tag;
        g     = -1;
        legal = 1'b0;
        word  = 0;
        if (rst_ni) begin
            case (req)
                2'b01:   g = 0;
                2'b10:   g = 1;
                2'b11:   g = 1 - last_gnt;
                default: g = -1;
            endcase
        end
        if (g >= 0) begin
            off   = addr[g*32 +: 32];
            legal = !we[g] && (off < 32'h0000_1000);
            word  = legal ? int'(off >> 2) : 0;
        end
        for (int d = 0; d < 2; d++) begin
            tag = $sformatf("d%0d c%0d", d, cyc);
            hit = 1'b0;
`ifdef ROM_LINE_BUF_EN
            hit = legal && buf_v[d] && (buf_w[d] == word);
`endif
            access = legal && !hit;
            check({tag, " gnt"}, {30'd0, gnt[d]}, (g < 0) ? 32'd0 : ((g == 0) ? 32'd1 : 32'd2));
            check({tag, " csb"}, {31'd0, csb[d]}, {31'd0, !access});
            check({tag, " rom_addr"}, {22'd0, raddr[d]}, access ? 32'(word) : 32'(last_addr[d]));
            s = slot[d][cyc % 8];
            for (int p = 0; p < 2; p++) begin
                bit          ev;
                logic [31:0] ed;
                ev = s.v && (s.port == p);
                ed = ev ? s.data : held[d][p];
                check($sformatf("%s rvalid%0d", tag, p), {31'd0, rvalid[d][p]}, {31'd0, ev});
                check($sformatf("%s err%0d", tag, p), {31'd0, err[d][p]}, {31'd0, ev && s.err});
                check($sformatf("%s rdata%0d", tag, p), rdata[d][p*32 +: 32], ed);
                if (ev) held[d][p] = s.data;
            end
            if (s.v && s.fill) begin
                buf_v[d] = 1'b1;
                buf_w[d] = s.word;
            end
            slot[d][cyc % 8].v = 1'b0;
            if (g >= 0) begin
                slot[d][(cyc + lat(d)) % 8] = '{v: 1'b1, port: g, err: !legal,
                    data: legal ? mem[word] : 32'd0, fill: access, word: word};
                if (access) last_addr[d] = word;
            end
        end
        if (g >= 0) last_gnt = g;
    endtask

    task automatic step(input logic [1:0] r, input logic [1:0] w,
                        input logic [31:0] a0, input logic [31:0] a1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        req    = r;
        we     = w;
        addr   = {a1, a0};
        #1 cycle_check();
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00, 32'd0, 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        req    = 2'b00;
        we     = 2'b00;
        clear_model();
        #1 cycle_check();
        cyc++;
    endtask

    function automatic logic [31:0] rand_addr();
        int k;
        k = $urandom_range(0, 9);
        if (k == 0)      return 32'h0000_1000 + ($urandom & 32'h00FF_FFFF);
        else if (k < 6)  return 32'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
        else             return 32'($urandom_range(0, 4095));
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[4] = 32'hDEAD_BEEF;
        cyc = 0;
        clear_model();
        pulse_reset();

        // Single port-0 read of word 4.
        step(2'b01, 2'b00, 32'h0000_0010, 32'd0);
        idle(4);

        // Leave port 1 as last granted, then both ports contend for four cycles.
        step(2'b10, 2'b00, 32'd0, 32'h0000_0020);
        idle(3);
        for (int i = 0; i < 4; i++) step(2'b11, 2'b00, 32'h0000_0000, 32'h0000_0004);
        idle(4);

        // Out-of-range read then a write, both from port 1.
        step(2'b10, 2'b00, 32'd0, 32'h0000_1000);
        step(2'b10, 2'b10, 32'd0, 32'h0000_0008);
        idle(4);

        // Back-to-back port-0 reads of words 1, 2, 3.
        step(2'b01, 2'b00, 32'h0000_0004, 32'd0);
        step(2'b01, 2'b00, 32'h0000_0008, 32'd0);
        step(2'b01, 2'b00, 32'h0000_000C, 32'd0);
        idle(5);

        // Repeated read of word 7 with gap cycles.
        step(2'b01, 2'b00, 32'h0000_001C, 32'd0);
        idle(5);
        step(2'b01, 2'b00, 32'h0000_001E, 32'd0);
        idle(5);

        // Reset with two reads in flight; nothing may come back afterwards.
        step(2'b01, 2'b00, 32'h0000_0040, 32'd0);
        step(2'b10, 2'b00, 32'd0, 32'h0000_0044);
        pulse_reset();
        idle(6);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [1:0] r;
            logic [1:0] w;
            r    = 2'($urandom);
            w[0] = ($urandom_range(0, 7) == 0);
            w[1] = ($urandom_range(0, 7) == 0);
            step(r, w, rand_addr(), rand_addr());
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
